// File: rtl/btn_cond_pkg.sv
// Shared types for the push-button conditioner: channel indices and the
// counter command bundle with its priority arbitration.
package btn_cond_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    BTN_START = 2'd0,
    BTN_STOP  = 2'd1,
    BTN_RST   = 2'd2,
    BTN_DISP  = 2'd3
  } btn_id_e;

  typedef struct packed {
    logic start;
    logic stop;
    logic rst;
  } cnt_cmd_t;

  // Coincident presses resolve rst > stop > start so counter_top never sees two commands at once.
  function automatic cnt_cmd_t arbitrate(input logic press_start,
                                         input logic press_stop,
                                         input logic press_rst);
    cnt_cmd_t cmd;
    cmd.rst   = press_rst;
    cmd.stop  = press_stop & ~press_rst;
    cmd.start = press_start & ~press_stop & ~press_rst;
    return cmd;
  endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Board-button side and counter-command side of btn_cond bundled as one port.
interface btn_cond_if;
  import btn_cond_pkg::*;

  logic               btn_start_i;
  logic               btn_stop_i;
  logic               btn_rst_i;
  logic               btn_disp_i;
  logic               cnt_start;
  logic               cnt_stop;
  logic               cnt_rst;
  logic               disp_tgl;
  logic [NUM_BTN-1:0] btn_db;

  modport master (
    output btn_start_i, btn_stop_i, btn_rst_i, btn_disp_i,
    input  cnt_start, cnt_stop, cnt_rst, disp_tgl, btn_db
  );

  modport slave (
    input  btn_start_i, btn_stop_i, btn_rst_i, btn_disp_i,
    output cnt_start, cnt_stop, cnt_rst, disp_tgl, btn_db
  );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, stability counter and a registered
// pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic press_o
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             db_p2;
  logic             press_p2;
  logic [DEB_W-1:0] cnt_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      db_p2    <= 1'b0;
      press_p2 <= 1'b0;
      cnt_p2   <= '0;
    end else begin
      // p0/p1: metastability guard for the asynchronous board input
      sync_p0  <= raw_i;
      sync_p1  <= sync_p0;
      // p2: any cycle of agreement restarts qualification from zero
      press_p2 <= 1'b0;
      if (sync_p1 == db_p2) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
        db_p2    <= sync_p1;
        cnt_p2   <= '0;
        press_p2 <= sync_p1;
      end else begin
        cnt_p2 <= cnt_p2 + DEB_W'(1);
      end
    end
  end

  assign db_o    = db_p2;
  assign press_o = press_p2;

endmodule

// File: rtl/btn_cond.sv
// Push-button conditioner feeding counter_top: four debounced channels,
// prioritised one-cycle counter commands and a display toggle level.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic     clk,
  input logic     rst,
  btn_cond_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [NUM_BTN-1:0] raw_p;
  logic [NUM_BTN-1:0] db;
  logic [NUM_BTN-1:0] press;
  logic               disp_q;
  cnt_cmd_t           cmd;

  // Normalise polarity so every channel sees 1 = pressed.
  assign raw_p = {bus.btn_disp_i, bus.btn_rst_i, bus.btn_stop_i, bus.btn_start_i}
               ^ {NUM_BTN{ACTIVE_LOW}};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_p[i]),
      .db_o   (db[i]),
      .press_o(press[i])
    );
  end

  always_comb begin
    cmd = arbitrate(press[BTN_START], press[BTN_STOP], press[BTN_RST]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= 1'b0;
    end else if (press[BTN_DISP]) begin
      disp_q <= ~disp_q;
    end
  end

  assign bus.cnt_start = cmd.start;
  assign bus.cnt_stop  = cmd.stop;
  assign bus.cnt_rst   = cmd.rst;
  assign bus.disp_tgl  = disp_q;
  assign bus.btn_db    = db;

endmodule

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: table of per-cycle button waveforms with hand-derived
// expected outputs, applied to an active-high and an active-low instance.
module tb_btn_cond;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_cond_if bus_hi ();
  btn_cond_if bus_lo ();

  btn_cond #(.DEB_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .bus(bus_hi)
  );
  btn_cond #(.DEB_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .bus(bus_lo)
  );

  typedef struct packed {
    logic start;
    logic stop;
    logic rst;
    logic disp;
  } out_t;

  typedef struct {
    string       name;
    int          len;
    logic [63:0] b_start, b_stop, b_rst, b_disp, a_rst;
    logic [63:0] e_start, e_stop, e_rst, e_disp;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];
  out_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] b(input int i);
    logic [63:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic s, input logic p, input logic r, input logic d);
    bus_hi.btn_start_i = s;
    bus_hi.btn_stop_i  = p;
    bus_hi.btn_rst_i   = r;
    bus_hi.btn_disp_i  = d;
    bus_lo.btn_start_i = ~s;
    bus_lo.btn_stop_i  = ~p;
    bus_lo.btn_rst_i   = ~r;
    bus_lo.btn_disp_i  = ~d;
  endtask

  task automatic check_out(input string tag, input int k, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got {start,stop,rst,disp}=%b want %b", tag, k, act, exp);
    end
  endtask

  task automatic check_db(input string tag, input logic [3:0] act);
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL %s btn_db got %b want 0000", tag, act);
    end
  endtask

  function automatic vec_t mk(input string name, input int len);
    vec_t v;
    v.name = name;  v.len = len;
    v.b_start = '0; v.b_stop = '0; v.b_rst = '0; v.b_disp = '0; v.a_rst = '0;
    v.e_start = '0; v.e_stop = '0; v.e_rst = '0; v.e_disp = '0;
    return v;
  endfunction

  initial begin
    out_t act_hi, act_lo, exp;

    // Display first so the following reset must clear a set disp_tgl.
    vecs[0] = mk("display", 64);
    vecs[0].b_disp  = m(0, 9) | m(20, 29) | m(40, 49);
    vecs[0].e_disp  = m(6, 25) | m(46, 63);

    vecs[1] = mk("clean_start", 32);
    vecs[1].b_start = m(0, 19);
    vecs[1].e_start = b(5);

    vecs[2] = mk("bounce_stop", 32);
    vecs[2].b_stop  = m(0, 1) | m(4, 5) | m(8, 31);
    vecs[2].e_stop  = b(13);

    vecs[3] = mk("glitch_rst", 32);
    vecs[3].b_rst   = m(0, 2) | m(10, 31);
    vecs[3].e_rst   = b(15);

    vecs[4] = mk("simultaneous", 32);
    vecs[4].b_start = m(0, 11) | m(20, 31);
    vecs[4].b_stop  = m(0, 11) | m(20, 31);
    vecs[4].b_rst   = m(0, 11);
    vecs[4].e_rst   = b(5);
    vecs[4].e_stop  = b(25);

    vecs[5] = mk("rst_mid_count", 32);
    vecs[5].b_start = m(0, 31);
    vecs[5].a_rst   = b(4);
    vecs[5].e_start = b(10);

    vecs[6] = mk("restart_on_agree", 32);
    vecs[6].b_start = m(0, 2) | m(4, 31);
    vecs[6].e_start = b(9);

    vecs[7] = mk("release_glitch", 32);
    vecs[7].b_start = m(0, 11) | m(14, 31);
    vecs[7].e_start = b(5);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < NVEC; v++) begin
      // Two reset edges with buttons released, then the reset state is checked.
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #1;
      check_out({vecs[v].name, "/reset_hi"}, -1,
                {bus_hi.cnt_start, bus_hi.cnt_stop, bus_hi.cnt_rst, bus_hi.disp_tgl}, 4'b0000);
      check_out({vecs[v].name, "/reset_lo"}, -1,
                {bus_lo.cnt_start, bus_lo.cnt_stop, bus_lo.cnt_rst, bus_lo.disp_tgl}, 4'b0000);
      check_db({vecs[v].name, "/reset_hi"}, bus_hi.btn_db);
      check_db({vecs[v].name, "/reset_lo"}, bus_lo.btn_db);

      for (int k = 0; k < vecs[v].len; k++) begin
        @(negedge clk);
        rst = vecs[v].a_rst[k];
        drive(vecs[v].b_start[k], vecs[v].b_stop[k], vecs[v].b_rst[k], vecs[v].b_disp[k]);
        sb.push_back({vecs[v].e_start[k], vecs[v].e_stop[k], vecs[v].e_rst[k], vecs[v].e_disp[k]});
        @(posedge clk);
        #1;
        exp    = sb.pop_front();
        act_hi = {bus_hi.cnt_start, bus_hi.cnt_stop, bus_hi.cnt_rst, bus_hi.disp_tgl};
        act_lo = {bus_lo.cnt_start, bus_lo.cnt_stop, bus_lo.cnt_rst, bus_lo.disp_tgl};
        check_out({vecs[v].name, "/hi"}, k, act_hi, exp);
        check_out({vecs[v].name, "/lo"}, k, act_lo, exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
